// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants used by the fetch stage.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic [2:0] {
        BOOT,
        FETCH,
        WAIT,
        HOLD,
        KILL
    } fetch_state_e;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise bubble.
module if_id_reg #(
    parameter logic [riscv_pkg::XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter logic [riscv_pkg::XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       stall_i,
    input  logic                       load_i,
    input  logic [riscv_pkg::XLEN-1:0] instr_i,
    input  logic [riscv_pkg::XLEN-1:0] pc_i,
    output logic [riscv_pkg::XLEN-1:0] instr_o,
    output logic [riscv_pkg::XLEN-1:0] pc_o,
    output logic [riscv_pkg::XLEN-1:0] pc_plus4_o,
    output logic                       valid_o
);
    localparam int unsigned W = riscv_pkg::XLEN;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_o    <= NOP_INSTR;
            pc_o       <= RESET_PC;
            pc_plus4_o <= RESET_PC + W'(4);
            valid_o    <= 1'b0;
        end else if (flush_i) begin
            // PC fields keep their last value so debug still sees where we were.
            instr_o <= NOP_INSTR;
            valid_o <= 1'b0;
        end else if (stall_i) begin
            instr_o    <= instr_o;
            pc_o       <= pc_o;
            pc_plus4_o <= pc_plus4_o;
            valid_o    <= valid_o;
        end else if (load_i) begin
            instr_o    <= instr_i;
            pc_o       <= pc_i;
            pc_plus4_o <= pc_i + W'(4);
            valid_o    <= 1'b1;
        end else begin
            instr_o <= NOP_INSTR;
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues single-outstanding imem requests,
// buffers a response across stalls and discards responses made stale by redirects.
module fetch_stage #(
    parameter logic [riscv_pkg::XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter logic [riscv_pkg::XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       stall_i,
    input  logic                       flush_i,
    input  logic                       redirect_i,
    input  logic [riscv_pkg::XLEN-1:0] redirect_pc_i,
    output logic                       imem_req_o,
    output logic [riscv_pkg::XLEN-1:0] imem_addr_o,
    input  logic                       imem_rvalid_i,
    input  logic [riscv_pkg::XLEN-1:0] imem_rdata_i,
    output logic [riscv_pkg::XLEN-1:0] instr_o,
    output logic [riscv_pkg::XLEN-1:0] pc_o,
    output logic [riscv_pkg::XLEN-1:0] pc_plus4_o,
    output logic                       valid_o
);
    import riscv_pkg::*;

    localparam int unsigned W = XLEN;

    fetch_state_e   state_q, state_d;
    logic [W-1:0]   pc_q, pc_d;
    logic [W-1:0]   buf_q, buf_d;
    logic           req_q;
    logic           load_c;
    logic [W-1:0]   load_instr_c;
    logic [W-1:0]   target_c;
    logic [W-1:0]   pc_next_c;

    assign target_c  = align_pc(redirect_pc_i);
    assign pc_next_c = pc_q + W'(4);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            buf_q   <= NOP_INSTR;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            // Request is a flop so no input reaches imem_req_o combinationally.
            req_q   <= (state_d == FETCH);
        end
    end

    // Next-state, PC update and IF/ID load generation.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        load_c       = 1'b0;
        load_instr_c = imem_rdata_i;

        case (state_q)
            BOOT: state_d = FETCH;

            FETCH: begin
                if (redirect_i) begin
                    pc_d    = target_c;
                    state_d = KILL;
                end else begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (imem_rvalid_i) begin
                    if (redirect_i) begin
                        pc_d    = target_c;
                        state_d = FETCH;
                    end else if (!stall_i) begin
                        load_c  = 1'b1;
                        pc_d    = pc_next_c;
                        state_d = FETCH;
                    end else begin
                        buf_d   = imem_rdata_i;
                        state_d = HOLD;
                    end
                end else if (redirect_i) begin
                    pc_d    = target_c;
                    state_d = KILL;
                end
            end

            HOLD: begin
                if (redirect_i) begin
                    pc_d    = target_c;
                    state_d = FETCH;
                end else if (!stall_i) begin
                    load_c       = 1'b1;
                    load_instr_c = buf_q;
                    pc_d         = pc_next_c;
                    state_d      = FETCH;
                end
            end

            // Wait out the in-flight response of an abandoned request.
            KILL: begin
                if (redirect_i) begin
                    pc_d = target_c;
                end
                if (imem_rvalid_i) begin
                    state_d = FETCH;
                end
            end

            default: state_d = BOOT;
        endcase
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = pc_q;

    if_id_reg #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .stall_i    (stall_i),
        .load_i     (load_c),
        .instr_i    (load_instr_c),
        .pc_i       (pc_q),
        .instr_o    (instr_o),
        .pc_o       (pc_o),
        .pc_plus4_o (pc_plus4_o),
        .valid_o    (valid_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected IF/ID contents,
// a negedge monitor pops them whenever decode consumes a valid instruction.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    fetch_stage dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .valid_o       (valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.pc4   = pc4;
        exp_q.push_back(e);
    endtask

    task automatic resp(input logic [31:0] data);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = data;
        tick();
        imem_rvalid_i = 1'b0;
    endtask

    // Bounded wait for a request, check its address, then let it be accepted.
    task automatic expect_req(input string nm, input logic [31:0] addr);
        int i = 0;
        while (!imem_req_o && i < 8) begin
            tick();
            i++;
        end
        chk({nm, "_req"}, 32'(imem_req_o), 32'd1);
        if (imem_req_o) chk({nm, "_addr"}, imem_addr_o, addr);
        tick();
    endtask

    // Monitor: one pop per instruction decode actually takes.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && valid_o === 1'b1 && stall_i === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected: got instr %h pc %h expected nothing", instr_o, pc_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_instr", instr_o, e.instr);
                chk("sb_pc", pc_o, e.pc);
                chk("sb_pc4", pc_plus4_o, e.pc4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni        = 1'b0;
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        repeat (2) @(posedge clk_i);
        #1;

        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_instr", instr_o, 32'h0000_0013);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_pc4", pc_plus4_o, 32'h4);

        // Basic two-instruction stream with 1-cycle memory.
        rst_ni = 1'b1;
        tick();
        chk("boot_valid", 32'(valid_o), 32'd0);
        expect_req("t1_0", 32'h0);
        chk("t1_pre_valid", 32'(valid_o), 32'd0);
        push(32'h0050_0093, 32'h0, 32'h4);
        resp(32'h0050_0093);
        chk("t1_valid_edge3", 32'(valid_o), 32'd1);
        expect_req("t1_4", 32'h4);
        push(32'h00A0_0113, 32'h4, 32'h8);
        resp(32'h00A0_0113);

        // Stall across a response: HOLD, no request, frozen outputs.
        expect_req("t2_8", 32'h8);
        stall_i       = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hFE00_0EE3;
        tick();
        imem_rvalid_i = 1'b0;
        repeat (2) begin
            chk("t2_noreq", 32'(imem_req_o), 32'd0);
            chk("t2_frozen_pc", pc_o, 32'h4);
            tick();
        end
        stall_i = 1'b0;
        chk("t2_noreq_last", 32'(imem_req_o), 32'd0);
        push(32'hFE00_0EE3, 32'h8, 32'hC);
        tick();
        chk("t2_release_valid", 32'(valid_o), 32'd1);
        chk("t2_release_instr", instr_o, 32'hFE00_0EE3);

        // Redirect while waiting; late response must be dropped.
        expect_req("t3_c", 32'hC);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        tick();
        redirect_i = 1'b0;
        tick();
        resp(32'hDEAD_BEEF);
        chk("t3_dropped", 32'(valid_o), 32'd0);
        expect_req("t3_100", 32'h100);
        resp(32'h1234_5678);

        // Flush together with stall squashes the shown word.
        flush_i = 1'b1;
        stall_i = 1'b1;
        expect_req("t4_104", 32'h104);
        flush_i = 1'b0;
        stall_i = 1'b0;
        chk("t4_valid", 32'(valid_o), 32'd0);
        chk("t4_instr", instr_o, 32'h0000_0013);
        chk("t4_pc_hold", pc_o, 32'h100);
        chk("t4_pc4_hold", pc_plus4_o, 32'h104);

        // Response coinciding with redirect; target alignment.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0102;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBADB_AD00;
        tick();
        redirect_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        chk("t5_drop_valid", 32'(valid_o), 32'd0);
        chk("t5_req", 32'(imem_req_o), 32'd1);
        chk("t5_align", imem_addr_o, 32'h100);

        // Redirect in FETCH to the top word, then PC wraps to zero.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        resp(32'h0BAD_0001);
        expect_req("t5_top", 32'hFFFF_FFFC);
        push(32'h0010_0073, 32'hFFFF_FFFC, 32'h0);
        resp(32'h0010_0073);
        expect_req("t5_wrap", 32'h0);

        // Asynchronous reset in WAIT.
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_valid", 32'(valid_o), 32'd0);
        chk("t6_req", 32'(imem_req_o), 32'd0);
        chk("t6_pc", pc_o, 32'h0);
        chk("t6_pc4", pc_plus4_o, 32'h4);
        chk("t6_instr", instr_o, 32'h0000_0013);
        tick();
        rst_ni        = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_BAD0;
        tick();
        imem_rvalid_i = 1'b0;
        chk("t6_late_ignored", 32'(valid_o), 32'd0);
        expect_req("t6_0", 32'h0);
        push(32'h0050_0093, 32'h0, 32'h4);
        resp(32'h0050_0093);
        chk("t6_valid_after", 32'(valid_o), 32'd1);

        repeat (3) tick();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage with an IF/ID pipeline register. It owns the PC and issues single-outstanding requests to instruction memory. It buffers the returned word and presents instr_o/pc_o to decode, where instr_o[31:7] drives immediate extension and instr_o drives the control decoder. It supports downstream stall, pipeline flush and PC redirect from branch/jump resolution.

Parameters:
RESET_PC, 32'h0000_0000, PC value fetched first after reset.
NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) driven on instr_o when invalid.

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  reset, asynchronous, active-low.
stall_i  input  1  decode cannot accept; IF/ID register holds.
flush_i  input  1  squash IF/ID contents to bubble.
redirect_i  input  1  replace fetch PC with redirect_pc_i.
redirect_pc_i  input  32  redirect target; bits [1:0] ignored (forced 00).
imem_req_o  output  1  fetch request; accepted by memory in the same cycle it is high.
imem_addr_o  output  32  word-aligned fetch address, valid while imem_req_o=1.
imem_rvalid_i  input  1  response valid, at least 1 cycle after request, in order.
imem_rdata_i  input  32  instruction word, valid with imem_rvalid_i.
instr_o  output  32  IF/ID instruction.
pc_o  output  32  IF/ID PC of instr_o.
pc_plus4_o  output  32  pc_o+4 (registered), used for JAL/JALR link.
valid_o  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, rst_ni=0): state=BOOT, pc_q=RESET_PC, instr_o=NOP_INSTR, pc_o=RESET_PC, pc_plus4_o=RESET_PC+4, valid_o=0, imem_req_o=0.
- imem_req_o=1 only in state FETCH; imem_addr_o=pc_q. At most one request outstanding. There is no combinational path from inputs to imem_req_o/imem_addr_o.
- States and transitions:
  - BOOT: next cycle → FETCH.
  - FETCH: request issued → WAIT. If redirect_i: pc_q<=redirect_pc_i, → KILL (the issued request is discarded).
  - WAIT, case by case:
    - rvalid & redirect: drop data, pc_q<=redirect target, → FETCH.
    - rvalid & !stall: load IF/ID (instr, pc_q, pc_q+4, valid=1), pc_q<=pc_q+4, → FETCH.
    - rvalid & stall: capture word into hold buffer, → HOLD.
    - !rvalid & redirect: pc_q<=target, → KILL.
  - HOLD: redirect → discard buffer, pc_q<=target, → FETCH. Else if !stall: load IF/ID from buffer, pc_q<=pc_q+4, → FETCH. Else stay.
  - KILL: rvalid → discard, → FETCH. A redirect in KILL overwrites pc_q again and stays in KILL, or goes to FETCH if rvalid is also high.
- IF/ID register priority, highest first:
  - flush_i: valid_o<=0, instr_o<=NOP_INSTR; pc_o and pc_plus4_o hold. This wins over stall.
  - stall_i: all outputs hold.
  - load event: outputs updated as listed above.
  - otherwise: bubble (valid_o<=0, instr_o<=NOP_INSTR).
- A load and a flush in the same cycle: flush wins and the word is lost. The PC is still advanced; the controller always pairs flush with redirect.
- Latency: minimum 2 cycles per instruction (request, then response with zero-wait memory). First valid_o at the 3rd rising edge after reset release when rvalid returns 1 cycle after request.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0.

Decomposition:
- Shared riscv_pkg holds:
  - fetch_state_e enum {BOOT, FETCH, WAIT, HOLD, KILL};
  - NOP_INSTR constant;
  - RESET_PC default;
  - XLEN=32.
- Natural sub-module: if_id_reg, the output register implementing the flush/stall/load/bubble priority. The FSM and PC stay in fetch_stage.

Test Plan:
- Reset release, 1-cycle memory returning 0x00500093, 0x00A00113 → valid_o rises on 3rd edge with pc_o=0, instr_o=0x00500093; next valid at pc_o=4, pc_plus4_o=8.
- stall_i held 3 cycles while a response arrives (data 0xFE000EE3) → FSM enters HOLD, outputs frozen, no new imem_req_o. After stall drops, instr_o=0xFE000EE3 in 1 cycle.
- redirect_i to 0x0000_0100 while in WAIT, with response 0xDEADBEEF arriving 2 cycles later → word dropped, valid_o never shows it, next imem_addr_o=0x100.
- flush_i and stall_i together → valid_o=0, instr_o=0x00000013 next edge.
- redirect_pc_i=0x0000_0102 → imem_addr_o=0x0000_0100. PC at 0xFFFF_FFFC → next fetch address 0x0000_0000.
- rst_ni pulled low mid-WAIT → immediately valid_o=0, imem_req_o=0, pc_o=RESET_PC. A late rvalid after release is ignored (state BOOT/FETCH).
